ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU. Consumes the post-forwarding

---
 rtl/ex_muldiv_if.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage multiply/divide unit signal bundle
interface ex_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1_ALU;
  logic [31:0] in2_ALU;
  logic        mf_req;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;

  modport master (
    output start, op, in1_ALU, in2_ALU, mf_req, flush,
    input  hi, lo, busy, done, stall_req
  );

  modport slave (
    input  start, op, in1_ALU, in2_ALU, mf_req, flush,
    output hi, lo, busy, done, stall_req
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO
module ex_muldiv_unit #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  bus
);
  localparam int K        = MUL_BITS_PER_CYCLE;
  localparam int MUL_ITER = 32 / K;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;   // MUL: shifting multiplicand; DIV: divisor in [31:0]
  logic [31:0] mplier_q, mplier_d; // MUL: shifting multiplier; DIV: dividend shifting out, quotient in
  logic [63:0] acc_q, acc_d;       // MUL: product; DIV: partial remainder in [31:0]
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic        rs_neg, rt_neg;
  logic [31:0] abs_rs, abs_rt;
  logic [63:0] partial;
  logic [32:0] shifted, diff;
  logic [63:0] product;
  logic [31:0] quot, rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    signed_op = (bus.op == 3'd0) || (bus.op == 3'd2);
    rs_neg    = signed_op & bus.in1_ALU[31];
    rt_neg    = signed_op & bus.in2_ALU[31];
    abs_rs    = rs_neg ? (32'd0 - bus.in1_ALU) : bus.in1_ALU;
    abs_rt    = rt_neg ? (32'd0 - bus.in2_ALU) : bus.in2_ALU;

    partial = 64'd0;
    for (int i = 0; i < K; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end

    shifted = {acc_q[31:0], mplier_q[31]};
    diff    = shifted - {1'b0, mcand_q[31:0]};

    product = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quot    = neg_res_q ? (32'd0 - mplier_q) : mplier_q;
    rem     = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            3'd0, 3'd1: begin
              state_d   = S_MUL;
              mcand_d   = {32'd0, abs_rs};
              mplier_d  = abs_rt;
              acc_d     = 64'd0;
              cnt_d     = 6'd0;
              neg_res_d = rs_neg ^ rt_neg;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
              is_div_d  = 1'b0;
            end
            3'd2, 3'd3: begin
              state_d   = S_DIV;
              mcand_d   = {32'd0, abs_rt};
              mplier_d  = abs_rs;
              acc_d     = 64'd0;
              cnt_d     = 6'd0;
              neg_res_d = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
              dz_d      = (bus.in2_ALU == 32'd0);
              is_div_d  = 1'b1;
            end
            3'd4:    hi_d = bus.in1_ALU;
            3'd5:    lo_d = bus.in1_ALU;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!diff[32]) begin
          acc_d    = {32'd0, diff[31:0]};
          mplier_d = {mplier_q[30:0], 1'b1};
        end else begin
          acc_d    = {32'd0, shifted[31:0]};
          mplier_d = {mplier_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero yields all-ones quotient; remainder already equals raw rs.
          lo_d = dz_q ? 32'hFFFF_FFFF : quot;
          hi_d = rem;
        end else begin
          hi_d = product[63:32];
          lo_d = product[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      acc_q     <= 64'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.stall_req = !reset && (state_q != S_IDLE) && (bus.start || bus.mf_req);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized bench with arithmetic reference model for ex_muldiv_unit
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  logic reset4;

  ex_muldiv_if bus ();
  ex_muldiv_if bus4 ();

  ex_muldiv_unit #(.MUL_BITS_PER_CYCLE(1)) dut  (.clk(clk), .reset(reset),  .bus(bus.slave));
  ex_muldiv_unit #(.MUL_BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4.slave));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain arithmetic, with the two architectural special cases.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int qa, qb;
    logic [63:0] up;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_busy, m_done;
  int          m_left;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else if (m_busy) begin
      m_done = 0;
      if (bus.flush) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_busy = 0; m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (bus.start && !bus.flush) begin
        case (bus.op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {r_hi, r_lo} = ref_res(bus.op, bus.in1_ALU, bus.in2_ALU);
            m_busy = 1;
            m_left = 33;
          end
          3'd4:    m_hi = bus.in1_ALU;
          3'd5:    m_lo = bus.in1_ALU;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("stall_req", {31'd0, bus.stall_req},
          {31'd0, !reset && m_busy && (bus.start || bus.mf_req)});
    end
  end

  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mf, input logic fl, input logic rst);
    @(negedge clk);
    #1;
    bus.start = st; bus.op = op; bus.in1_ALU = a; bus.in2_ALU = b;
    bus.mf_req = mf; bus.flush = fl; reset = rst;
  endtask

  task automatic idle();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      idle();
      if (!m_busy) break;
    end
    idle();
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int dones);
    lat = 0; dones = 0;
    drive(1'b1, op, a, b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) lat++;
      if (bus.done) dones++;
      #1;
      bus.start = 1'b0;
      if (!bus.busy && bus.done) break;
    end
  endtask

  task automatic run4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo);
    int lat, dones;
    lat = 0; dones = 0;
    @(negedge clk); #1;
    bus4.start = 1'b1; bus4.op = op; bus4.in1_ALU = a; bus4.in2_ALU = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus4.busy) lat++;
      if (bus4.done) dones++;
      #1;
      bus4.start = 1'b0;
      if (!bus4.busy && bus4.done) break;
    end
    chk("x4_latency", lat, 9);
    chk("x4_done_pulses", dones, 1);
    chk("x4_hi", bus4.hi, ehi);
    chk("x4_lo", bus4.lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  int lat, dones, stalls;

  initial begin
    bus.start = 0; bus.op = 6; bus.in1_ALU = 0; bus.in2_ALU = 0; bus.mf_req = 0; bus.flush = 0;
    bus4.start = 0; bus4.op = 6; bus4.in1_ALU = 0; bus4.in2_ALU = 0; bus4.mf_req = 0; bus4.flush = 0;
    reset = 1; reset4 = 1;
    repeat (2) drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    reset4 = 0;
    chk_en = 1'b1;
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    run4(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run4(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, lat, dones);
    chk("mult_latency", lat, 33);
    chk("mult_done_pulses", dones, 1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, dones);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, dones);
    chk("div_latency", lat, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, dones);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'd0);

    run_op(3'd3, 32'd5, 32'd0, lat, dones);
    chk("divu0_latency", lat, 33);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd5);

    drive(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mtlo_lo", bus.lo, 32'h1234);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    idle();

    // MULT in flight while MFHI and a second MULT are held upstream.
    stalls = 0;
    drive(1'b1, 3'd0, 32'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall_req) stalls++;
      #1;
      bus.mf_req = 1'b1; bus.in1_ALU = 32'd7; bus.in2_ALU = 32'd9;
      if (!bus.busy) break;
    end
    chk("stall_cycles", stalls, 33);
    chk("mfhi_new_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mfhi_new_lo", bus.lo, 32'hFFFF_FFFA);
    idle();
    @(negedge clk);
    chk("second_mult_started", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    chk("second_mult_lo", bus.lo, 32'd63);

    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    repeat (9) idle();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_lo", bus.lo, 32'd63);
    chk("flush_hi", bus.hi, 32'd0);
    repeat (40) idle();
    chk("flush_lo_late", bus.lo, 32'd63);

    drive(1'b1, 3'd0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    repeat (9) idle();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_lo", bus.lo, 32'd0);
    chk("midreset_hi", bus.hi, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 3) == 0, 3'($urandom % 8), pick(), pick(),
            ($urandom % 4) == 0, ($urandom % 150) == 0, ($urandom % 1000) == 0);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
